// File: rtl/add64_word_sequencer_pkg.sv
// Shared constants and encodings for the word-wide front end of the 64-bit adder.
package add64_word_sequencer_pkg;

  localparam int W = 32;
  localparam int N = 64;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    CALC = 2'd1,
    OUT  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    BEAT_ALO = 2'd0,
    BEAT_AHI = 2'd1,
    BEAT_BLO = 2'd2,
    BEAT_BHI = 2'd3
  } beat_t;

endpackage

// File: rtl/add64_word_sequencer_if.sv
// Operand-beat input handshake and result output handshake of the sequencer.
interface add64_word_sequencer_if #(
  parameter int W = add64_word_sequencer_pkg::W,
  parameter int N = add64_word_sequencer_pkg::N
);

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         in_cin;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_sum;
  logic         out_cout;
  logic         busy;

  // Producer of beats and consumer of results.
  modport master (
    output in_valid, in_data, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, busy
  );

  // The sequencer itself.
  modport slave (
    input  in_valid, in_data, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout, busy
  );

endinterface

// File: rtl/add64_word_sequencer_adder.sv
// Modular 64-bit adder built from two half-width adders; the carry between the
// halves ripples internally. The clock pin exists for drop-in compatibility and
// is not used by the combinational sum.
module adder64bitmodular #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout
);

  localparam int H = N / 2;

  logic         unused_clk;
  logic [H:0]   lo_sum;
  logic [H:0]   hi_sum;

  assign unused_clk = clk;

  assign lo_sum = {1'b0, a[H-1:0]} + {1'b0, b[H-1:0]} + {{H{1'b0}}, cin};
  assign hi_sum = {1'b0, a[N-1:H]} + {1'b0, b[N-1:H]} + {{H{1'b0}}, lo_sum[H]};

  assign s    = {hi_sum[H-1:0], lo_sum[H-1:0]};
  assign cout = hi_sum[H];

endmodule

// File: rtl/add64_word_sequencer.sv
// Collects A and B as four W-bit beats, runs them through the modular adder for
// one cycle, and holds {cout,sum} on a valid/ready output until taken.
module add64_word_sequencer #(
  parameter int W = 32,
  parameter int N = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  add64_word_sequencer_if.slave   bus
);

  import add64_word_sequencer_pkg::*;

  if (N != 2 * W) begin : g_width_check
    $error("add64_word_sequencer: N must equal 2*W");
  end

  state_t       state;
  state_t       state_nxt;
  logic [1:0]   beat;
  logic         accept;

  logic [N-1:0] a_p0;
  logic [N-1:0] b_p0;
  logic         cin_p0;

  logic [N-1:0] sum_c;
  logic         cout_c;

  logic [N-1:0] sum_p1;
  logic         cout_p1;
  logic         vld_p1;

  // Beats are only taken in LOAD, and never while reset is asserted.
  assign bus.in_ready = (state == LOAD) && !rst;
  assign accept       = bus.in_valid && bus.in_ready;

  // Next-state decision for the LOAD -> CALC -> OUT cycle.
  always_comb begin
    state_nxt = state;
    unique case (state)
      LOAD:    if (accept && (beat == BEAT_BHI)) state_nxt = CALC;
      CALC:    state_nxt = OUT;
      OUT:     if (bus.out_ready) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  // ---- stage p0: operand assembly from bus beats ----
  // Steer each accepted beat into its operand half; the counter wraps 3 -> 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat   <= 2'd0;
      a_p0   <= '0;
      b_p0   <= '0;
      cin_p0 <= 1'b0;
    end else if (accept) begin
      unique case (beat)
        BEAT_ALO: a_p0[W-1:0] <= bus.in_data;
        BEAT_AHI: a_p0[N-1:W] <= bus.in_data;
        BEAT_BLO: b_p0[W-1:0] <= bus.in_data;
        BEAT_BHI: begin
          b_p0[N-1:W] <= bus.in_data;
          cin_p0      <= bus.in_cin;
        end
        default: ;
      endcase
      beat <= beat + 2'd1;
    end
  end

  adder64bitmodular #(
    .N (N)
  ) u_adder (
    .clk  (clk),
    .a    (a_p0),
    .b    (b_p0),
    .cin  (cin_p0),
    .s    (sum_c),
    .cout (cout_c)
  );

  // ---- stage p1: registered result ----
  // Capture the adder output during CALC; it then stays put through OUT and beyond.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_p1  <= '0;
      cout_p1 <= 1'b0;
    end else if (state == CALC) begin
      sum_p1  <= sum_c;
      cout_p1 <= cout_c;
    end
  end

  assign vld_p1 = (state == OUT);

  assign bus.out_valid = vld_p1;
  assign bus.out_sum   = sum_p1;
  assign bus.out_cout  = cout_p1;
  assign bus.busy      = !((state == LOAD) && (beat == 2'd0));

endmodule

// File: tb/tb_add64_word_sequencer.sv
// Scenario bench for add64_word_sequencer: expected sums are queued when the
// operands are sent and popped when a result appears.
module tb_add64_word_sequencer;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  add64_word_sequencer_if #(.W(32), .N(64)) ifc ();

  add64_word_sequencer #(.W(32), .N(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc   = 0;
  logic [64:0] exp_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  // Present one beat and hold it until the DUT takes it; returns just after the accepting edge.
  task automatic drive_beat(input logic [31:0] d, input logic c, output int e, output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    ifc.in_valid = 1'b1;
    ifc.in_data  = d;
    ifc.in_cin   = c;
    while (!ifc.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = ifc.in_ready;
    @(posedge clk);
    #1;
    e = cyc;
  endtask

  // Send A and B as four beats; idle `gap` cycles between beats; queue the expected result.
  task automatic send_txn(input logic [63:0] a, input logic [63:0] b, input logic c,
                          input int gap, input logic junk, input bit hold,
                          output int e_last, output bit ok);
    logic [31:0] w [4];
    bit          k;
    w[0] = a[31:0];
    w[1] = a[63:32];
    w[2] = b[31:0];
    w[3] = b[63:32];
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_beat(w[i], (i == 3) ? c : junk, e_last, k);
      ok = ok && k;
      if (gap > 0 && i < 3) begin
        ifc.in_valid = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
      end
    end
    if (!hold) ifc.in_valid = 1'b0;
    exp_q.push_back({1'b0, a} + {1'b0, b} + {64'd0, c});
  endtask

  // Wait (bounded) for out_valid, sampling at negedges; reports what was seen.
  task automatic wait_result(output logic [64:0] got, output int waited,
                             output int at_cyc, output bit seen);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!ifc.out_valid && waited < 100);
    seen   = ifc.out_valid;
    got    = {ifc.out_cout, ifc.out_sum};
    at_cyc = cyc;
  endtask

  // Pulse out_ready for one edge from a negedge.
  task automatic take_result();
    ifc.out_ready = 1'b1;
    @(posedge clk);
    #1;
    ifc.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ifc.in_valid  = 1'b0;
    ifc.in_data   = '0;
    ifc.in_cin    = 1'b0;
    ifc.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (ifc.in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready: got %b want 0", ifc.in_ready); end
    n_cmp++; if (ifc.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", ifc.out_valid); end
    n_cmp++; if ({ifc.out_cout, ifc.out_sum} !== 65'd0) begin n_bad++; $display("FAIL reset_result: got %h want 0", {ifc.out_cout, ifc.out_sum}); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (ifc.in_ready !== 1'b1) begin n_bad++; $display("FAIL post_reset_in_ready: got %b want 1", ifc.in_ready); end
    n_cmp++; if (ifc.busy !== 1'b0) begin n_bad++; $display("FAIL post_reset_busy: got %b want 0", ifc.busy); end
  endtask

  task automatic test_full_carry();
    int e, waited, at;
    bit ok, seen;
    logic [64:0] got, exp;
    send_txn(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 0, 1'b0, 1'b0, e, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL full_carry_send: got timeout want accept"); end
    wait_result(got, waited, at, seen);
    exp = exp_q.pop_front();
    n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL full_carry_sum: got %h want %h", got, exp); end
    n_cmp++; if (waited !== 2 || !seen) begin n_bad++; $display("FAIL full_carry_latency: got %0d edges want 2", waited); end
    take_result();
    @(negedge clk);
    n_cmp++; if (ifc.out_valid !== 1'b0) begin n_bad++; $display("FAIL full_carry_drop: got %b want 0", ifc.out_valid); end
  endtask

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        c;
    logic        junk;
  } vec_t;

  task automatic test_carry_paths();
    vec_t v [3];
    int e, waited, at;
    bit ok, seen;
    logic [64:0] got, exp;
    v[0] = '{64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 1'b0};
    v[1] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 1'b0};
    v[2] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      send_txn(v[i].a, v[i].b, v[i].c, 0, v[i].junk, 1'b0, e, ok);
      wait_result(got, waited, at, seen);
      exp = exp_q.pop_front();
      n_cmp++; if (!ok || !seen || got !== exp) begin n_bad++; $display("FAIL carry_path_%0d: got %h want %h", i, got, exp); end
      take_result();
    end
  endtask

  task automatic test_stalls();
    int e, waited, at;
    bit ok, seen;
    logic [64:0] got, exp;
    send_txn(64'h1234, 64'h10, 1'b0, 3, 1'b0, 1'b0, e, ok);
    wait_result(got, waited, at, seen);
    exp = exp_q.pop_front();
    n_cmp++; if (!ok || !seen || got !== exp) begin n_bad++; $display("FAIL stall_sum: got %h want %h", got, exp); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++; if (ifc.out_valid !== 1'b1 || {ifc.out_cout, ifc.out_sum} !== exp) begin
        n_bad++; $display("FAIL stall_hold_%0d: got v=%b %h want v=1 %h", i, ifc.out_valid, {ifc.out_cout, ifc.out_sum}, exp);
      end
      n_cmp++; if (ifc.in_ready !== 1'b0 || ifc.busy !== 1'b1) begin
        n_bad++; $display("FAIL stall_flags_%0d: got ready=%b busy=%b want ready=0 busy=1", i, ifc.in_ready, ifc.busy);
      end
    end
    take_result();
    @(negedge clk);
    n_cmp++; if (ifc.out_valid !== 1'b0 || ifc.in_ready !== 1'b1) begin
      n_bad++; $display("FAIL stall_release: got valid=%b ready=%b want valid=0 ready=1", ifc.out_valid, ifc.in_ready);
    end
  endtask

  task automatic test_reset_mid_load();
    int e, waited, at;
    bit ok, seen;
    logic [64:0] got, exp;
    drive_beat(32'hDEAD_BEEF, 1'b0, e, ok);
    drive_beat(32'hCAFE_F00D, 1'b0, e, ok);
    ifc.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (ifc.in_ready !== 1'b0) begin n_bad++; $display("FAIL midload_rst_ready: got %b want 0", ifc.in_ready); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (ifc.out_valid !== 1'b0 || ifc.busy !== 1'b0) begin
      n_bad++; $display("FAIL midload_flags: got valid=%b busy=%b want 0 0", ifc.out_valid, ifc.busy);
    end
    send_txn(64'd5, 64'd7, 1'b1, 0, 1'b0, 1'b0, e, ok);
    wait_result(got, waited, at, seen);
    exp = exp_q.pop_front();
    n_cmp++; if (!ok || !seen || got !== exp) begin n_bad++; $display("FAIL midload_sum: got %h want %h", got, exp); end
    take_result();
  endtask

  task automatic test_reset_in_out();
    int e, waited, at;
    bit ok, seen;
    logic [64:0] got, exp;
    send_txn(64'h42, 64'h24, 1'b0, 0, 1'b0, 1'b0, e, ok);
    wait_result(got, waited, at, seen);
    exp = exp_q.pop_front();
    n_cmp++; if (!ok || !seen || got !== exp) begin n_bad++; $display("FAIL out_rst_sum: got %h want %h", got, exp); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (ifc.out_valid !== 1'b0 || ifc.busy !== 1'b0) begin
      n_bad++; $display("FAIL out_rst_drop: got valid=%b busy=%b want 0 0", ifc.out_valid, ifc.busy);
    end
  endtask

  task automatic test_back_to_back();
    ifc.out_ready = 1'b1;
    fork
      begin
        int e;
        bit ok;
        for (int i = 1; i <= 3; i++) begin
          send_txn(64'(i), 64'(i) << 32, 1'b0, 0, 1'b0, 1'b1, e, ok);
          n_cmp++; if (!ok) begin n_bad++; $display("FAIL b2b_send_%0d: got timeout want accept", i); end
        end
      end
      begin
        int waited, at, prev;
        bit seen;
        logic [64:0] got, exp;
        prev = 0;
        for (int k = 0; k < 3; k++) begin
          wait_result(got, waited, at, seen);
          exp = (exp_q.size() > 0) ? exp_q.pop_front() : 65'h1_FFFF_FFFF_FFFF_FFFF;
          n_cmp++; if (!seen || got !== exp) begin n_bad++; $display("FAIL b2b_sum_%0d: got %h want %h", k, got, exp); end
          if (k > 0) begin
            n_cmp++; if (at - prev !== 6) begin n_bad++; $display("FAIL b2b_period_%0d: got %0d want 6", k, at - prev); end
          end
          prev = at;
        end
      end
    join
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_carry();
    test_carry_paths();
    test_stalls();
    test_reset_mid_load();
    test_reset_in_out();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
